rf_wb_arbiter: RTL

- Write-back arbiter and pending-write scoreboard for the 32x32 register file's single synchronous write port.
- Shares that port between NREQ write-back sources (e.g. ALU, load unit, mul/div) using round-robin arbitration.
- Drives the register file's waddr/wdata/w_en from a registered output stage.
- Tracks registers reserved at issue but not yet written, for hazard/stall logic.

---
 rtl/rf_wb_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin write-back arbiter for the register file's single
// write port, with a registered write stage and a pending-write scoreboard.
// Optional combinational read bypass of the in-flight write: RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_addr,
`ifdef RF_WB_BYPASS_EN
    input  logic [ADDR_W-1:0]        byp_raddr1,
    input  logic [ADDR_W-1:0]        byp_raddr2,
    input  logic [DATA_W-1:0]        byp_rfdata1,
    input  logic [DATA_W-1:0]        byp_rfdata2,
    output logic [DATA_W-1:0]        byp_rdata1,
    output logic [DATA_W-1:0]        byp_rdata2,
`endif
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic                     rf_w_en,
    output logic [31:0]              busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]  ptr_reg;
    logic [PTR_W-1:0]  ptr_next;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  scan_idx;
    logic [NREQ-1:0]   grant_next;
    logic              found;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              w_en_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [31:0]       busy_reg;

    // Round-robin search: start at the pointer, walk upward with wrap, first valid wins.
    always_comb begin
        grant_next = '0;
        found      = 1'b0;
        win_idx    = '0;
        scan_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = PTR_W'((int'(ptr_reg) + k) % NREQ);
            if (!found && req_valid[scan_idx]) begin
                grant_next[scan_idx] = 1'b1;
                win_idx              = scan_idx;
                found                = 1'b1;
            end
        end
    end

    // No grants while reset is held, so nothing is accepted and then dropped.
    assign req_ready = rst ? '0 : grant_next;
    assign xfer      = |req_ready;
    assign ptr_next  = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    assign sel_addr  = req_addr[win_idx*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[win_idx*DATA_W +: DATA_W];

    // Registered write stage and pointer advance; address 0 consumes its slot but never writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_en_reg  <= 1'b0;
            waddr_reg <= '0;
            wdata_reg <= '0;
            ptr_reg   <= '0;
        end else if (xfer) begin
            w_en_reg  <= (sel_addr != '0);
            waddr_reg <= sel_addr;
            wdata_reg <= sel_data;
            ptr_reg   <= ptr_next;
        end else begin
            w_en_reg  <= 1'b0;
        end
    end

    // A write accepted just before reset is squashed while reset is high.
    assign rf_w_en  = w_en_reg & ~rst;
    assign rf_waddr = waddr_reg;
    assign rf_wdata = wdata_reg;

    assign busy_reg[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_busy
            // Per-register pending flag: a new reservation beats a same-cycle completion.
            always_ff @(posedge clk) begin
                if (rst) begin
                    busy_reg[gi] <= 1'b0;
                end else if (rsv_valid && (rsv_addr == ADDR_W'(gi))) begin
                    busy_reg[gi] <= 1'b1;
                end else if (w_en_reg && (waddr_reg == ADDR_W'(gi))) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign busy = busy_reg;

`ifdef RF_WB_BYPASS_EN
    // Forward the write in flight so readers see the new value in its write cycle.
    assign byp_rdata1 = (rf_w_en && (rf_waddr == byp_raddr1) && (byp_raddr1 != '0)) ? rf_wdata : byp_rfdata1;
    assign byp_rdata2 = (rf_w_en && (rf_waddr == byp_raddr2) && (byp_raddr2 != '0)) ? rf_wdata : byp_rfdata2;
`endif

endmodule
